div_seq: RTL and testbench

Sequential radix-2 divider that serves the execute stage's multi-cycle divide request. It accepts a 32-bit dividend/divisor pair with a signedness flag over the `opn_valid`/`res_ready`/`res_valid` handshake. It computes the quotient and remainder in a fixed number of cycles using restoring division on operand magnitudes. It returns `{remainder, quotient}` for the HI/LO write path, with MIPS DIV/DIVU semantics.

---
 rtl/div_seq_if.sv | 24 ++
 rtl/div_seq.sv | 157 +++++++++++++++
 tb/tb_div_seq.sv | 136 +++++++++++++
 3 files changed

// File: rtl/div_seq_if.sv
// Request/response bundle between the execute stage and the sequential divider.
interface div_seq_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               sign;
    logic               opn_valid;
    logic               res_ready;
    logic               res_valid;
    logic [2*WIDTH-1:0] result;

    // Requester side: drives operands and handshake, receives the result.
    modport master (
        output a, b, sign, opn_valid, res_ready,
        input  res_valid, result
    );

    // Divider side.
    modport slave (
        input  a, b, sign, opn_valid, res_ready,
        output res_valid, result
    );
endinterface

// File: rtl/div_seq.sv
// Sequential radix-2 restoring divider with MIPS DIV/DIVU semantics.
// Works on operand magnitudes, fixes signs in a final cycle and returns
// {remainder, quotient} through a registered one-cycle res_valid pulse.
module div_seq #(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst,
    div_seq_if.slave bus
);
    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_SIGN = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Two's-complement negate when en is set; the magnitude of the most
    // negative value stays 2^(WIDTH-1), which is exact as an unsigned value.
    function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic en);
        logic [WIDTH-1:0] r;
        if (en) begin
            r = ~v + WIDTH'(1);
        end else begin
            r = v;
        end
        return r;
    endfunction

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               sign_q, sign_d;
    logic               neg_a_q, neg_a_d;
    logic               neg_b_q, neg_b_d;
    logic [WIDTH-1:0]   dvd_q, dvd_d;    // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0]   dvs_q, dvs_d;    // divisor magnitude
    logic [WIDTH-1:0]   rem_q, rem_d;    // partial remainder
    logic               res_valid_q, res_valid_d;
    logic [2*WIDTH-1:0] result_q, result_d;

    logic [WIDTH:0]     shifted_s;
    logic [WIDTH:0]     sub_s;
    logic               ge_s;
    logic [WIDTH-1:0]   step_rem_s;
    logic [WIDTH-1:0]   step_dvd_s;
    logic               unused_ok_s;

    // res_ready is informational; the top subtract bit is always zero when taken.
    assign unused_ok_s = bus.res_ready ^ sub_s[WIDTH];

    assign bus.res_valid = res_valid_q;
    assign bus.result    = result_q;

    // One restoring step: shift {rem, dvd} left, trial-subtract the divisor
    // on WIDTH+1 bits so a 2^(WIDTH-1) magnitude never overflows.
    always_comb begin
        shifted_s  = {rem_q, dvd_q[WIDTH-1]};
        sub_s      = shifted_s - {1'b0, dvs_q};
        ge_s       = (shifted_s >= {1'b0, dvs_q});
        step_dvd_s = {dvd_q[WIDTH-2:0], ge_s};
        if (ge_s) begin
            step_rem_s = sub_s[WIDTH-1:0];
        end else begin
            step_rem_s = shifted_s[WIDTH-1:0];
        end
    end

    // Next-state and datapath control for the IDLE/BUSY/SIGN/DONE sequence.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sign_d      = sign_q;
        neg_a_d     = neg_a_q;
        neg_b_d     = neg_b_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        rem_d       = rem_q;
        res_valid_d = 1'b0;
        result_d    = result_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.opn_valid) begin
                    sign_d  = bus.sign;
                    neg_a_d = bus.sign & bus.a[WIDTH-1];
                    neg_b_d = bus.sign & bus.b[WIDTH-1];
                    dvd_d   = neg_if(bus.a, bus.sign & bus.a[WIDTH-1]);
                    dvs_d   = neg_if(bus.b, bus.sign & bus.b[WIDTH-1]);
                    rem_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_BUSY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (!bus.opn_valid) begin
                    state_d = ST_IDLE;
                end else begin
                    rem_d = step_rem_s;
                    dvd_d = step_dvd_s;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_SIGN;
                    end else begin
                        state_d = ST_BUSY;
                    end
                end
            end
            ST_SIGN: begin
                if (!bus.opn_valid) begin
                    state_d = ST_IDLE;
                end else begin
                    result_d    = {neg_if(rem_q, sign_q & neg_a_q),
                                   neg_if(dvd_q, sign_q & (neg_a_q ^ neg_b_q))};
                    res_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs; reset discards any operation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            sign_q      <= 1'b0;
            neg_a_q     <= 1'b0;
            neg_b_q     <= 1'b0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            res_valid_q <= 1'b0;
            result_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sign_q      <= sign_d;
            neg_a_q     <= neg_a_d;
            neg_b_q     <= neg_b_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            rem_q       <= rem_d;
            res_valid_q <= res_valid_d;
            result_q    <= result_d;
        end
    end
endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: hand-computed quotient/remainder vectors,
// latency, pulse width, abort, back-to-back and asynchronous reset.
module tb_div_seq;
    logic clk;
    logic rst_n;
    int   check_cnt;
    int   err_cnt;

    div_seq_if #(.WIDTH(32)) bus ();

    div_seq #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        check_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Issue one divide, scramble operands after acceptance, then check
    // latency, result, single-cycle pulse and result hold.
    task automatic run_div(input string tag, input logic [31:0] a_v, input logic [31:0] b_v,
                           input logic s_v, input logic [63:0] exp_v);
        int  n;
        logic seen;
        bus.a         = a_v;
        bus.b         = b_v;
        bus.sign      = s_v;
        bus.opn_valid = 1'b1;
        @(posedge clk); #1;
        bus.a    = ~a_v;
        bus.b    = ~b_v;
        bus.sign = ~s_v;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 100) begin
            @(posedge clk); #1;
            n++;
            if (bus.res_valid) seen = 1'b1;
        end
        bus.opn_valid = 1'b0;
        check_val({tag, "_lat"}, 64'(n), 64'd33);
        check_val(tag, bus.result, exp_v);
        @(posedge clk); #1;
        check_val({tag, "_pulse"}, 64'(bus.res_valid), 64'd0);
        check_val({tag, "_hold"}, bus.result, exp_v);
    endtask

    // Watch a window of cycles and return how many res_valid pulses occurred.
    task automatic count_pulses(input int cycles, output int pulses);
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (bus.res_valid) pulses++;
        end
    endtask

    // Main directed sequence.
    initial begin
        int pulses;
        check_cnt     = 0;
        err_cnt       = 0;
        rst_n         = 1'b0;
        bus.a         = 32'd0;
        bus.b         = 32'd0;
        bus.sign      = 1'b0;
        bus.opn_valid = 1'b0;
        bus.res_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_valid", 64'(bus.res_valid), 64'd0);
        check_val("rst_result", bus.result, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_div("u_100_7",    32'd100,         32'd7,           1'b0, {32'd2,           32'd14});
        run_div("s_m7_2",     32'hFFFF_FFF9,   32'd2,           1'b1, {32'hFFFF_FFFF,   32'hFFFF_FFFD});
        run_div("s_7_m2",     32'd7,           32'hFFFF_FFFE,   1'b1, {32'd1,           32'hFFFF_FFFD});
        run_div("s_min_m1",   32'h8000_0000,   32'hFFFF_FFFF,   1'b1, {32'd0,           32'h8000_0000});
        run_div("u_max_1",    32'hFFFF_FFFF,   32'd1,           1'b0, {32'd0,           32'hFFFF_FFFF});
        run_div("u_min_max",  32'h8000_0000,   32'hFFFF_FFFF,   1'b0, {32'h8000_0000,   32'd0});
        run_div("u_div0",     32'h1234_5678,   32'd0,           1'b0, {32'h1234_5678,   32'hFFFF_FFFF});
        run_div("s_div0",     32'h1234_5678,   32'd0,           1'b1, {32'h1234_5678,   32'hFFFF_FFFF});
        run_div("u_100_7b",   32'd100,         32'd7,           1'b0, {32'd2,           32'd14});

        // Abort: start 50/5, drop the request 10 cycles in.
        bus.a         = 32'd50;
        bus.b         = 32'd5;
        bus.sign      = 1'b0;
        bus.opn_valid = 1'b1;
        @(posedge clk); #1;
        repeat (10) @(posedge clk);
        #1;
        bus.opn_valid = 1'b0;
        count_pulses(40, pulses);
        check_val("abort_pulses", 64'(pulses), 64'd0);
        check_val("abort_result", bus.result, {32'd2, 32'd14});

        // Re-raise the same request; it must complete normally.
        run_div("u_50_5", 32'd50, 32'd5, 1'b0, {32'd0, 32'd10});

        // Asynchronous reset in the middle of BUSY.
        bus.a         = 32'd100;
        bus.b         = 32'd7;
        bus.sign      = 1'b0;
        bus.opn_valid = 1'b1;
        @(posedge clk); #1;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_valid", 64'(bus.res_valid), 64'd0);
        check_val("mid_rst_result", bus.result, 64'd0);
        bus.opn_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        count_pulses(40, pulses);
        check_val("post_rst_pulses", 64'(pulses), 64'd0);
        check_val("post_rst_result", bus.result, 64'd0);

        $display("Result: errors=%0d of %0d checks", err_cnt, check_cnt);
        $finish;
    end
endmodule
